// File: rtl/spi_sram_responder_if.sv
// SPI link between a serial-SRAM controller (master) and the responder (slave).
// Mode 0 wiring: sclk idles low, cs active-low, MSB first.
interface spi_sram_responder_if;
    logic sclk;
    logic cs;
    logic mosi;
    logic miso;

    modport master (output sclk, output cs, output mosi, input miso);
    modport slave  (input sclk, input cs, input mosi, output miso);
endinterface

// File: rtl/spi_sram_responder.sv
// Serial-SRAM responder: decodes READ 0x03 / WRITE 0x02 with 16/24-bit address over
// SPI mode 0, backs them with an internal byte array and supports burst access.
module spi_sram_responder #(
    parameter int ADDR_BITS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    spi_sram_responder_if.slave     spi,
    input  logic                    addr_24bit,
    output logic                    busy,
    output logic                    wr_strobe,
    output logic [ADDR_BITS-1:0]    wr_addr,
    output logic [7:0]              wr_data
);

    typedef enum logic [2:0] {
        IDLE, COMMAND, ADDRESS, WRITE_DATA, READ_DATA, IGNORE
    } state_t;

    state_t               state_q, state_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           tx_q, tx_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 is_read_q, is_read_d;
    logic                 addr24_q, addr24_d;
    logic                 sclk_q, sclk_d;
    logic                 miso_q, miso_d;
    logic                 busy_q, busy_d;
    logic                 wr_strobe_q, wr_strobe_d;
    logic [ADDR_BITS-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]           wr_data_q, wr_data_d;

    // Contents are deliberately not reset; they persist across transactions and rst.
    logic [7:0]           mem [2**ADDR_BITS];
    logic [7:0]           rd_byte;
    logic [7:0]           rx_byte;
    logic                 mem_we;
    logic                 rise, fall;
    logic [4:0]           addr_last;

    assign rise      = spi.sclk & ~sclk_q;
    assign fall      = ~spi.sclk & sclk_q;
    assign rd_byte   = mem[addr_q];
    assign rx_byte   = {shift_q[6:0], spi.mosi};
    assign addr_last = addr24_q ? 5'd23 : 5'd15;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        tx_d        = tx_q;
        addr_d      = addr_q;
        is_read_d   = is_read_q;
        addr24_d    = addr24_q;
        sclk_d      = spi.sclk;
        miso_d      = miso_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        mem_we      = 1'b0;

        // Deasserted chip select overrides everything, including a coincident rise.
        if (spi.cs) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d   = COMMAND;
                    bit_cnt_d = '0;
                    addr24_d  = addr_24bit;
                    miso_d    = 1'b0;
                end
                COMMAND: begin
                    if (rise) begin
                        shift_d = rx_byte;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = '0;
                            if (rx_byte == 8'h03) begin
                                is_read_d = 1'b1;
                                state_d   = ADDRESS;
                            end else if (rx_byte == 8'h02) begin
                                is_read_d = 1'b0;
                                state_d   = ADDRESS;
                            end else begin
                                state_d   = IGNORE;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                ADDRESS: begin
                    if (rise) begin
                        addr_d = {addr_q[ADDR_BITS-2:0], spi.mosi};
                        if (bit_cnt_q == addr_last) begin
                            bit_cnt_d = '0;
                            state_d   = is_read_q ? READ_DATA : WRITE_DATA;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                WRITE_DATA: begin
                    if (rise) begin
                        shift_d = rx_byte;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d   = '0;
                            mem_we      = ~rst;
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = addr_q;
                            wr_data_d   = rx_byte;
                            addr_d      = addr_q + 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                end
                READ_DATA: begin
                    if (rise) begin
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = '0;
                            addr_d    = addr_q + 1'b1;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 5'd1;
                        end
                    end
                    // First fall of each byte fetches it; later falls shift it out.
                    if (fall) begin
                        if (bit_cnt_q == 5'd0) begin
                            miso_d = rd_byte[7];
                            tx_d   = {rd_byte[6:0], 1'b0};
                        end else begin
                            miso_d = tx_q[7];
                            tx_d   = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                default: begin
                    miso_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            tx_q        <= '0;
            addr_q      <= '0;
            is_read_q   <= 1'b0;
            addr24_q    <= 1'b0;
            sclk_q      <= 1'b0;
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            tx_q        <= tx_d;
            addr_q      <= addr_d;
            is_read_q   <= is_read_d;
            addr24_q    <= addr24_d;
            sclk_q      <= sclk_d;
            miso_q      <= miso_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr_q] <= rx_byte;
        end
    end

    assign spi.miso  = miso_q;
    assign busy      = busy_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_spi_sram_responder.sv
// Directed bench for spi_sram_responder: acts as the SPI controller (sclk = clk/4)
// and checks write strobes, read-back data, ignore/abort handling and mid-read reset.
module tb_spi_sram_responder;

    logic       clk;
    logic       rst;
    logic       addr_24bit;
    logic       busy;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;

    int compare_count;
    int fail_count;
    int strobe_count;
    logic [7:0] strobe_addr [$];
    logic [7:0] strobe_data [$];
    logic [7:0] rx;

    spi_sram_responder_if spi_bus ();

    spi_sram_responder #(.ADDR_BITS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .spi        (spi_bus),
        .addr_24bit (addr_24bit),
        .busy       (busy),
        .wr_strobe  (wr_strobe),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every committed byte; a strobe longer than one cycle shows up as an extra entry.
    always @(negedge clk) begin
        if (!rst && wr_strobe) begin
            strobe_count++;
            strobe_addr.push_back(wr_addr);
            strobe_data.push_back(wr_data);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compare_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Shift the top nbits of tx_byte out on mosi, capturing miso just before each rise.
    task automatic applyStimulus(input int nbits, input logic [7:0] tx_byte, output logic [7:0] rx_byte);
        rx_byte = '0;
        for (int i = 7; i > 7 - nbits; i--) begin
            @(negedge clk);
            spi_bus.sclk = 1'b0;
            spi_bus.mosi = tx_byte[i];
            @(negedge clk);
            @(negedge clk);
            rx_byte = {rx_byte[6:0], spi_bus.miso};
            spi_bus.sclk = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic spiBegin(input logic a24);
        @(negedge clk);
        spi_bus.cs = 1'b0;
        addr_24bit = a24;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic spiEnd();
        @(negedge clk);
        spi_bus.sclk = 1'b0;
        @(negedge clk);
        spi_bus.cs = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic sendByte(input logic [7:0] b);
        logic [7:0] dummy;
        applyStimulus(8, b, dummy);
    endtask

    task automatic readOne16(input logic [7:0] a, input logic [7:0] expected, input string tag);
        logic [7:0] got;
        spiBegin(1'b0);
        sendByte(8'h03);
        sendByte(8'h00);
        sendByte(a);
        applyStimulus(8, 8'h00, got);
        checkOutput(tag, {24'h0, got}, {24'h0, expected});
        spiEnd();
    endtask

    initial begin
        compare_count = 0;
        fail_count    = 0;
        strobe_count  = 0;
        rst           = 1'b1;
        addr_24bit    = 1'b0;
        spi_bus.sclk  = 1'b0;
        spi_bus.cs    = 1'b1;
        spi_bus.mosi  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkOutput("reset_miso",    {31'h0, spi_bus.miso}, 32'h0);
        checkOutput("reset_busy",    {31'h0, busy},         32'h0);
        checkOutput("reset_strobe",  {31'h0, wr_strobe},    32'h0);
        checkOutput("reset_wr_addr", {24'h0, wr_addr},      32'h0);
        checkOutput("reset_wr_data", {24'h0, wr_data},      32'h0);

        // 16-bit single-byte write
        spiBegin(1'b0);
        checkOutput("busy_after_cs", {31'h0, busy}, 32'h1);
        sendByte(8'h02); sendByte(8'h00); sendByte(8'h12); sendByte(8'hA5);
        spiEnd();
        checkOutput("w16_count", strobe_count, 1);
        checkOutput("w16_addr",  {24'h0, strobe_addr[0]}, 32'h12);
        checkOutput("w16_data",  {24'h0, strobe_data[0]}, 32'hA5);
        checkOutput("w16_busy_low", {31'h0, busy}, 32'h0);

        readOne16(8'h12, 8'hA5, "r16_data");
        checkOutput("r16_miso_idle", {31'h0, spi_bus.miso}, 32'h0);

        // 24-bit burst write wrapping past the top of the array
        spiBegin(1'b1);
        sendByte(8'h02); sendByte(8'hAB); sendByte(8'h00); sendByte(8'hFF);
        sendByte(8'h11); sendByte(8'h22); sendByte(8'h33);
        spiEnd();
        checkOutput("burst_count", strobe_count, 4);
        checkOutput("burst_addr0", {24'h0, strobe_addr[1]}, 32'hFF);
        checkOutput("burst_addr1", {24'h0, strobe_addr[2]}, 32'h00);
        checkOutput("burst_addr2", {24'h0, strobe_addr[3]}, 32'h01);
        checkOutput("burst_data0", {24'h0, strobe_data[1]}, 32'h11);
        checkOutput("burst_data2", {24'h0, strobe_data[3]}, 32'h33);

        spiBegin(1'b1);
        sendByte(8'h03); sendByte(8'h00); sendByte(8'h00); sendByte(8'hFF);
        applyStimulus(8, 8'h00, rx); checkOutput("burst_rd0", {24'h0, rx}, 32'h11);
        applyStimulus(8, 8'h00, rx); checkOutput("burst_rd1", {24'h0, rx}, 32'h22);
        applyStimulus(8, 8'h00, rx); checkOutput("burst_rd2", {24'h0, rx}, 32'h33);
        spiEnd();

        // Unknown command: everything after it is ignored
        spiBegin(1'b1);
        sendByte(8'h05);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8, 8'hFF, rx);
            checkOutput("ignore_miso", {24'h0, rx}, 32'h0);
        end
        checkOutput("ignore_busy", {31'h0, busy}, 32'h1);
        spiEnd();
        checkOutput("ignore_no_strobe", strobe_count, 4);

        // Abort: a full write to 0x40, then a write cut off after 5 data bits
        spiBegin(1'b0);
        sendByte(8'h02); sendByte(8'h00); sendByte(8'h40); sendByte(8'h5A);
        spiEnd();
        spiBegin(1'b0);
        sendByte(8'h02); sendByte(8'h00); sendByte(8'h40);
        applyStimulus(5, 8'hC3, rx);
        spiEnd();
        checkOutput("abort_no_strobe", strobe_count, 5);
        readOne16(8'h40, 8'h5A, "abort_readback");

        // Reset in the middle of a read
        spiBegin(1'b0);
        sendByte(8'h03); sendByte(8'h00); sendByte(8'h12);
        applyStimulus(1, 8'h00, rx);
        checkOutput("pre_rst_miso", {31'h0, spi_bus.miso}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_miso", {31'h0, spi_bus.miso}, 32'h0);
        checkOutput("rst_busy", {31'h0, busy},         32'h0);
        rst = 1'b0;
        spi_bus.sclk = 1'b0;
        @(negedge clk);
        spi_bus.cs = 1'b1;
        repeat (2) @(negedge clk);
        readOne16(8'h12, 8'hA5, "post_rst_read");
        readOne16(8'hFF, 8'h11, "post_rst_read_ff");
        checkOutput("final_strobe_count", strobe_count, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
